reu_xfer_seq: RTL and testbench
===============================

// Module: reu_xfer_seq
// PURPOSE
//  DMA transfer sequencer for the REU. Consumes the register block's command state (Execute, XferType,
//  FF00 decode, Length1, IncMode) and runs the byte-by-byte C64<->REU RAM transfer, producing the
//  NextCA / NextREUA / XferEnd / VerifyErr pulses the register block uses to advance and retire a job.
//  Owns nDMA, C64 bus direction/enables and REU RAM write strobe. Clocked on falling edge of PHI2.
// PARAMETERS
//  DMA_SETTLE   1   falling edges to wait after nDMA asserted and BA high before first DMA cycle (1..7)
// PORTS
//  PHI2       in   1   system clock; all state changes on negedge
//  Reset      in   1   synchronous, active-high
//  Execute    in   1   command bit 7 from register block; job request while high
//  FF00En     in   1   1 = wait for CPU write to $FF00 before starting
//  FF00Wr     in   1   one-cycle pulse: CPU wrote $FF00
//  XferType   in   2   00 stash C64->REU, 01 fetch REU->C64, 10 swap, 11 verify
//  IncMode    in   2   bit1 = hold C64 address, bit0 = hold REU address
//  Length1    in   1   current length register == 1 (this byte is last)
//  BA         in   1   VIC bus-available; 0 = bus stolen, stall
//  C64DIn     in   8   C64 data bus read value
//  RamDIn     in   8   REU RAM read value
//  nDMA       out  1   active-low DMA request to C64
//  AddrOE     out  1   drive C64 address bus (CA) during DMA cycles
//  C64RW      out  1   1 = read C64, 0 = write C64
//  C64DOE     out  1   drive C64 data bus
//  C64DOut    out  8   data to C64
//  RamWE      out  1   REU RAM write strobe
//  RamDOut    out  8   data to REU RAM
//  NextCA     out  1   one-cycle pulse: advance CA and decrement Length
//  NextREUA   out  1   one-cycle pulse: advance REU address
//  XferEnd    out  1   one-cycle pulse: job completed
//  VerifyErr  out  1   one-cycle pulse: verify mismatch
// BEHAVIOUR
//  Reset: state IDLE; nDMA=1, AddrOE=0, C64RW=1, C64DOE=0, RamWE=0, all pulses 0, hold regs 0. Reset mid-job
//   aborts at that edge, nDMA released, no XferEnd/VerifyErr issued.
//  States: IDLE, ARM, REQ, SETTLE, XFER, SWAPWR, DONE.
//  IDLE: Execute=1 -> ARM if FF00En else REQ. ARM: FF00Wr=1 -> REQ (Execute=0 -> IDLE).
//  REQ: nDMA=0 from this state on; BA=1 -> SETTLE with counter=DMA_SETTLE-1. SETTLE: counter==0 && BA -> XFER.
//  XFER (one byte per PHI2 cycle, AddrOE=1; BA=0 -> stall: outputs hold, no pulses, no writes):
//   stash: C64RW=1, RamWE=1, RamDOut=C64DIn. fetch: C64RW=0, C64DOE=1, C64DOut=RamDIn.
//   verify: C64RW=1, compare C64DIn vs RamDIn at edge. swap: both reads, latch C64DIn->HoldC, RamDIn->HoldR,
//   go SWAPWR; SWAPWR: C64RW=0, C64DOE=1, C64DOut=HoldR, RamWE=1, RamDOut=HoldC.
//  Byte completion (edge leaving XFER, or SWAPWR for swap): NextCA=~IncMode[1], NextREUA=~IncMode[0].
//   NextCA also decrements Length, so with IncMode[1]=1 Length counting is owned by register block
//   (team rule: register block decrements on NextCA|ByteDone); expose ByteDone internally = completion.
//  Termination: completion with Length1=1 -> XferEnd pulse, -> DONE. Verify mismatch -> VerifyErr pulse,
//   -> DONE; mismatch on final byte -> VerifyErr and XferEnd same cycle. Otherwise stay XFER.
//  DONE: nDMA=1, buses released; wait Execute=0 (register block clears it on XferEnd/VerifyErr) -> IDLE.
//   No restart possible while Execute still high in DONE.
//  Simultaneous: BA drop on final byte delays completion and XferEnd until BA returns. FF00Wr outside ARM
//   ignored. Length wrap (0 means 65536) handled by register block; this block relies only on Length1.
//  Latency: Execute rise -> nDMA low 1 edge (FF00En=0); BA high -> first data cycle DMA_SETTLE+1 edges.
// CONFIGURATION
//  REU_SWAP_EN defined: swap (10) supported as above, 2 cycles/byte.
//  REU_SWAP_EN undefined: HoldC/HoldR and SWAPWR removed; XferType 10 executes as stash.
// TESTING
//  Stash 3 bytes, BA=1, IncMode=00: nDMA low 1 edge after Execute; 3 RamWE cycles with C64DIn; 3 NextCA/NextREUA; XferEnd on byte 3.
//  Fetch 2 bytes with BA=0 for 2 cycles during byte 1: byte 1 stalls 2 cycles, no pulses while stalled, XferEnd after byte 2.
//  Swap C64=$AA, RAM=$55: SWAPWR drives C64DOut=$55 and RamDOut=$AA; one NextCA per 2 cycles.
//  Verify 4 bytes, mismatch at byte 2: VerifyErr on byte 2, no XferEnd, nDMA released next edge, 2 NextCA total.
//  FF00En=1: no nDMA until FF00Wr pulse; Execute cleared in ARM returns to IDLE without DMA.
//  Reset asserted mid-XFER: next edge nDMA=1, RamWE=0, state IDLE, no XferEnd.

Source files
------------

// File: rtl/reu_xfer_seq.sv
// reu_xfer_seq: REU DMA transfer sequencer (stash/fetch/swap/verify), clocked on PHI2 falling edge.
// Define REU_SWAP_EN to build the two-cycle swap path; otherwise XferType 10 runs as stash.
module reu_xfer_seq #(
    parameter int DMA_SETTLE = 1
) (
    input  logic       PHI2,
    input  logic       Reset,
    input  logic       Execute,
    input  logic       FF00En,
    input  logic       FF00Wr,
    input  logic [1:0] XferType,
    input  logic [1:0] IncMode,
    input  logic       Length1,
    input  logic       BA,
    input  logic [7:0] C64DIn,
    input  logic [7:0] RamDIn,
    output logic       nDMA,
    output logic       AddrOE,
    output logic       C64RW,
    output logic       C64DOE,
    output logic [7:0] C64DOut,
    output logic       RamWE,
    output logic [7:0] RamDOut,
    output logic       NextCA,
    output logic       NextREUA,
    output logic       XferEnd,
    output logic       VerifyErr
);
`ifdef REU_SWAP_EN
    typedef enum logic [2:0] {IDLE, ARM, REQ, SETTLE, XFER, SWAPWR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ARM, REQ, SETTLE, XFER, DONE} state_t;
`endif
    localparam logic [2:0] SETTLE_INIT = 3'(DMA_SETTLE - 1);
    state_t state, state_nx;
    logic [2:0] cnt;
    logic [1:0] xtype;
    logic byte_done, mismatch;
`ifdef REU_SWAP_EN
    logic [7:0] hold_c, hold_r;
    assign xtype = XferType;
`else
    assign xtype = (XferType == 2'b10) ? 2'b00 : XferType;
`endif
    always_ff @(negedge PHI2) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
`ifdef REU_SWAP_EN
            hold_c <= '0;
            hold_r <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == REQ)
                cnt <= SETTLE_INIT;
            else if (state == SETTLE && cnt != '0)
                cnt <= cnt - 3'd1;
`ifdef REU_SWAP_EN
            if (state == XFER && BA && xtype == 2'b10) begin
                hold_c <= C64DIn;
                hold_r <= RamDIn;
            end
`endif
        end
    end
    always_comb begin
        state_nx = state;
        nDMA = 1'b1;
        AddrOE = 1'b0;
        C64RW = 1'b1;
        C64DOE = 1'b0;
        C64DOut = '0;
        RamWE = 1'b0;
        RamDOut = '0;
        byte_done = 1'b0;
        mismatch = 1'b0;
        case (state)
            IDLE: if (Execute) state_nx = FF00En ? ARM : REQ;
            ARM: state_nx = !Execute ? IDLE : (FF00Wr ? REQ : ARM);
            REQ: begin
                nDMA = 1'b0;
                if (BA) state_nx = SETTLE;
            end
            SETTLE: begin
                nDMA = 1'b0;
                if (cnt == '0 && BA) state_nx = XFER;
            end
            // write strobes are gated by BA so a stolen bus never sees a write
            XFER: begin
                nDMA = 1'b0;
                AddrOE = 1'b1;
                C64RW = !(xtype == 2'b01 && BA);
                C64DOE = xtype == 2'b01 && BA;
                C64DOut = (xtype == 2'b01) ? RamDIn : '0;
                RamWE = xtype == 2'b00 && BA;
                RamDOut = (xtype == 2'b00) ? C64DIn : '0;
                mismatch = xtype == 2'b11 && BA && C64DIn != RamDIn;
                byte_done = BA && xtype != 2'b10;
`ifdef REU_SWAP_EN
                if (BA && xtype == 2'b10) state_nx = SWAPWR;
`endif
            end
`ifdef REU_SWAP_EN
            SWAPWR: begin
                nDMA = 1'b0;
                AddrOE = 1'b1;
                C64RW = !BA;
                C64DOE = BA;
                C64DOut = hold_r;
                RamWE = BA;
                RamDOut = hold_c;
                byte_done = BA;
                if (BA) state_nx = XFER;
            end
`endif
            DONE: if (!Execute) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (byte_done && (Length1 || mismatch)) state_nx = DONE;
        // a reset edge aborts the job, so no completion may be reported in that cycle
        if (Reset) begin
            byte_done = 1'b0;
            mismatch = 1'b0;
        end
    end
    assign NextCA = byte_done && !IncMode[1];
    assign NextREUA = byte_done && !IncMode[0];
    assign XferEnd = byte_done && Length1;
    assign VerifyErr = mismatch;
endmodule

// File: tb/tb_reu_xfer_seq.sv
// tb_reu_xfer_seq: random and directed REU jobs checked against memory-level expectations.
module tb_reu_xfer_seq;
    localparam int SETTLE = 1;
    logic PHI2 = 1'b1, Reset = 1'b1, Execute = 1'b0, FF00En = 1'b0, FF00Wr = 1'b0;
    logic BA = 1'b1, Length1 = 1'b0;
    logic [1:0] XferType = '0, IncMode = '0;
    logic [7:0] C64DIn = '0, RamDIn = '0;
    logic nDMA, AddrOE, C64RW, C64DOE, RamWE, NextCA, NextREUA, XferEnd, VerifyErr;
    logic [7:0] C64DOut, RamDOut;
    logic [7:0] c64_mem [256];
    logic [7:0] reu_mem [256];
    int ca, ra, len;
    int n_chk = 0, n_fail = 0;

    always #5 PHI2 = ~PHI2;

    reu_xfer_seq #(.DMA_SETTLE(SETTLE)) dut (
        .PHI2(PHI2), .Reset(Reset), .Execute(Execute), .FF00En(FF00En), .FF00Wr(FF00Wr),
        .XferType(XferType), .IncMode(IncMode), .Length1(Length1), .BA(BA),
        .C64DIn(C64DIn), .RamDIn(RamDIn), .nDMA(nDMA), .AddrOE(AddrOE), .C64RW(C64RW),
        .C64DOE(C64DOE), .C64DOut(C64DOut), .RamWE(RamWE), .RamDOut(RamDOut),
        .NextCA(NextCA), .NextREUA(NextREUA), .XferEnd(XferEnd), .VerifyErr(VerifyErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(negedge PHI2);
        #1;
    endtask

    task automatic drive_data;
        C64DIn = c64_mem[ca[7:0]];
        RamDIn = reu_mem[ra[7:0]];
        Length1 = (len == 1);
    endtask

    function automatic logic [7:0] addr(input int base, input logic hold, input int k);
        return 8'(base + (hold ? 0 : k));
    endfunction

    task automatic run_job(input logic [1:0] typ, input logic [1:0] inc, input int n, input bit ff00,
                           input bit stalls, input int ca0, input int ra0, input int mis);
        logic [7:0] c_ref [256];
        logic [7:0] r_ref [256];
        logic [7:0] tmp, a, b;
        logic [1:0] t;
        int nb_exp, nb, cyc, nreq, first, last, nca, nra, nend, nerr, bad_c, bad_r;
        bit err_exp, done, comp;
        t = typ;
`ifndef REU_SWAP_EN
        if (typ == 2'b10) t = 2'b00;
`endif
        if (t == 2'b11) begin
            for (int k = 0; k < n; k++) reu_mem[addr(ra0, inc[0], k)] = c64_mem[addr(ca0, inc[1], k)];
            if (mis >= 0) reu_mem[addr(ra0, inc[0], mis)] = c64_mem[addr(ca0, inc[1], mis)] ^ 8'h5A;
        end
        c_ref = c64_mem;
        r_ref = reu_mem;
        nb_exp = n;
        err_exp = 0;
        for (int k = 0; k < n; k++) begin
            if (!err_exp) begin
                a = addr(ca0, inc[1], k);
                b = addr(ra0, inc[0], k);
                if (t == 2'b00) r_ref[b] = c_ref[a];
                else if (t == 2'b01) c_ref[a] = r_ref[b];
                else if (t == 2'b10) begin
                    tmp = c_ref[a];
                    c_ref[a] = r_ref[b];
                    r_ref[b] = tmp;
                end else if (c_ref[a] != r_ref[b]) begin
                    err_exp = 1;
                    nb_exp = k + 1;
                end
            end
        end
        ca = ca0; ra = ra0; len = n;
        XferType = typ; IncMode = inc; FF00En = ff00; BA = 1'b1;
        drive_data();
        Execute = 1'b1;
        if (ff00) begin
            repeat ($urandom_range(1, 4)) next_cycle();
            @(posedge PHI2);
            check("arm_wait_ndma", nDMA, 1);
            next_cycle();
            FF00Wr = 1'b1;
        end
        cyc = 0; nreq = -1; first = -1; last = -1;
        nb = 0; nca = 0; nra = 0; nend = 0; nerr = 0; done = 0;
        while (!done && cyc < 500) begin
            @(posedge PHI2);
            if (nreq < 0 && !nDMA) nreq = cyc;
            if (first < 0 && AddrOE) first = cyc;
            comp = AddrOE && BA && (t == 2'b11 ? 1'b1 : (t == 2'b01 ? !C64RW : RamWE));
            check("pulses", {NextCA, NextREUA, XferEnd, VerifyErr},
                  {comp && !inc[1], comp && !inc[0], comp && len == 1,
                   comp && t == 2'b11 && C64DIn != RamDIn});
            if (comp) begin
                if (t == 2'b00 || t == 2'b10) reu_mem[ra[7:0]] = RamDOut;
                if (t == 2'b01 || t == 2'b10) c64_mem[ca[7:0]] = C64DOut;
                nb++;
                if (!inc[1]) ca++;
                if (!inc[0]) ra++;
                len--;
            end
            nca += NextCA ? 1 : 0;
            nra += NextREUA ? 1 : 0;
            nend += XferEnd ? 1 : 0;
            nerr += VerifyErr ? 1 : 0;
            if (XferEnd || VerifyErr) begin
                done = 1;
                last = cyc;
            end
            next_cycle();
            FF00Wr = 1'b0;
            if (done) Execute = 1'b0;
            BA = (stalls && first >= 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            drive_data();
            cyc++;
        end
        check("timeout", done, 1);
        check("start_latency", nreq, 1);
        check("settle_latency", first - nreq, SETTLE + 1);
        check("bytes", nb, nb_exp);
        check("nextca_count", nca, inc[1] ? 0 : nb_exp);
        check("nextreua_count", nra, inc[0] ? 0 : nb_exp);
        check("xferend_count", nend, (!err_exp || nb_exp == n) ? 1 : 0);
        check("verifyerr_count", nerr, err_exp ? 1 : 0);
        if (!stalls) check("xfer_cycles", last - first + 1, t == 2'b10 ? 2 * nb_exp : nb_exp);
        bad_c = 0;
        bad_r = 0;
        for (int k = 0; k < 256; k++) begin
            if (c64_mem[k] !== c_ref[k]) bad_c++;
            if (reu_mem[k] !== r_ref[k]) bad_r++;
        end
        check("c64_mem", bad_c, 0);
        check("reu_mem", bad_r, 0);
        @(posedge PHI2);
        check("released", {nDMA, AddrOE, C64DOE, RamWE}, 4'b1000);
        next_cycle();
        FF00En = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            c64_mem[k] = 8'($urandom);
            reu_mem[k] = 8'($urandom);
        end
        repeat (2) next_cycle();
        @(posedge PHI2);
        check("reset_outs", {nDMA, AddrOE, C64RW, C64DOE, RamWE, NextCA, NextREUA, XferEnd, VerifyErr},
              9'b101000000);
        next_cycle();
        Reset = 1'b0;
        run_job(2'b00, 2'b00, 3, 0, 0, 10, 20, -1);
        run_job(2'b01, 2'b00, 2, 0, 1, 100, 120, -1);
        c64_mem[30] = 8'hAA;
        reu_mem[40] = 8'h55;
        run_job(2'b10, 2'b00, 1, 0, 0, 30, 40, -1);
        run_job(2'b11, 2'b00, 4, 0, 0, 50, 60, 1);
        run_job(2'b00, 2'b00, 2, 1, 0, 70, 80, -1);
        // FF00 armed job abandoned before the trigger write
        FF00En = 1'b1;
        Execute = 1'b1;
        repeat (3) next_cycle();
        @(posedge PHI2);
        check("arm_no_dma", nDMA, 1);
        next_cycle();
        Execute = 1'b0;
        next_cycle();
        FF00Wr = 1'b1;
        next_cycle();
        FF00Wr = 1'b0;
        @(posedge PHI2);
        check("ff00wr_idle_ignored", nDMA, 1);
        next_cycle();
        FF00En = 1'b0;
        // reset in the middle of a stash, with the final byte presented in the reset cycle
        ca = 0; ra = 0; len = 5;
        XferType = 2'b00; IncMode = 2'b00; BA = 1'b1;
        drive_data();
        Execute = 1'b1;
        repeat (4) next_cycle();
        @(posedge PHI2);
        check("mid_xfer", {AddrOE, RamWE}, 2'b11);
        next_cycle();
        Reset = 1'b1;
        Execute = 1'b0;
        Length1 = 1'b1;
        @(posedge PHI2);
        check("reset_cycle_pulses", {XferEnd, VerifyErr}, 2'b00);
        next_cycle();
        @(posedge PHI2);
        check("reset_abort", {nDMA, RamWE, AddrOE, XferEnd}, 4'b1000);
        next_cycle();
        Reset = 1'b0;
        Length1 = 1'b0;
        next_cycle();
        for (int j = 0; j < 40; j++) begin
            int nn, mm;
            nn = int'($urandom_range(1, 6));
            mm = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, nn - 1)) : -1;
            run_job(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), nn,
                    $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), mm);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
